// File: rtl/sm4_key_expand_if.sv
// rtl/sm4_key_expand_if.sv - key-schedule control, key load and round-key read port
// master drives the key and read index; slave is the key-expansion engine.
interface sm4_key_expand_if;
  logic         key_start;
  logic [127:0] key_in;
  logic         key_busy;
  logic         key_ready;
  logic         rk_dec;
  logic [4:0]   rk_idx;
  logic [31:0]  rk_out;

  modport master (
    output key_start, key_in, rk_dec, rk_idx,
    input  key_busy, key_ready, rk_out
  );

  modport slave (
    input  key_start, key_in, rk_dec, rk_idx,
    output key_busy, key_ready, rk_out
  );
endinterface

// File: rtl/sm4_key_expand.sv
// rtl/sm4_key_expand.sv - iterative SM4 key schedule with a 32-entry round-key table
// One round key per clock; the table is read forward or reversed by round index.

module sm4_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  assign dout = SBOX[din];
endmodule

module sm4_key_expand #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  sm4_key_expand_if.slave kif
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] k0_q, k1_q, k2_q, k3_q;
  logic [31:0] rk_tab [32];
  logic        start_ok;
  logic [31:0] ck, t_word, tau_word, l_word, rk_new;
  logic [4:0]  rd_idx;

  // start is only honoured outside EXPAND, so a running schedule is never disturbed
  assign start_ok = kif.key_start && (state_q != EXPAND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (kif.key_start) state_d = EXPAND;
      EXPAND:  if (cnt_q == 5'd31) state_d = DONE;
      DONE:    if (kif.key_start) state_d = EXPAND;
      default: state_d = IDLE;
    endcase
  end

  assign kif.key_busy  = (state_q == EXPAND);
  assign kif.key_ready = (state_q == DONE);

  // CK byte j of round i is (4i + j) * 7 in 8-bit wrap arithmetic
  always_comb begin
    logic [7:0] base;
    ck   = '0;
    base = {1'b0, cnt_q, 2'b00};
    for (int j = 0; j < 4; j++) begin
      ck[31 - 8*j -: 8] = 8'((base + 8'(j)) * 8'd7);
    end
  end

  assign t_word = k1_q ^ k2_q ^ k3_q ^ ck;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sm4_sbox u_sbox (
      .din  (t_word[31 - 8*g -: 8]),
      .dout (tau_word[31 - 8*g -: 8])
    );
  end

  assign l_word = tau_word ^ {tau_word[18:0], tau_word[31:19]}
                           ^ {tau_word[8:0],  tau_word[31:9]};
  assign rk_new = k0_q ^ l_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      k0_q  <= '0;
      k1_q  <= '0;
      k2_q  <= '0;
      k3_q  <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
      k0_q  <= kif.key_in[127:96] ^ FK[127:96];
      k1_q  <= kif.key_in[95:64]  ^ FK[95:64];
      k2_q  <= kif.key_in[63:32]  ^ FK[63:32];
      k3_q  <= kif.key_in[31:0]   ^ FK[31:0];
    end else if (state_q == EXPAND) begin
      cnt_q <= cnt_q + 5'd1;
      k0_q  <= k1_q;
      k1_q  <= k2_q;
      k2_q  <= k3_q;
      k3_q  <= rk_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rk_tab[i] <= '0;
    end else if (state_q == EXPAND) begin
      rk_tab[cnt_q] <= rk_new;
    end
  end

  // reversed order for decryption: 31 - idx is a bitwise NOT of a 5-bit index
  assign rd_idx = kif.rk_idx ^ {5{kif.rk_dec}};

  if (OUT_REG) begin : g_out_reg
    logic [31:0] rk_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rk_q <= '0;
      else        rk_q <= rk_tab[rd_idx];
    end
    assign kif.rk_out = rk_q;
  end else begin : g_out_comb
    assign kif.rk_out = rk_tab[rd_idx];
  end
endmodule

// File: tb/tb_sm4_key_expand.sv
// tb/tb_sm4_key_expand.sv - directed bench for sm4_key_expand
// Known-answer round keys plus a reference key-schedule model for full tables.
module tb_sm4_key_expand;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] exp_rk [32];

  localparam logic [127:0] KEY_STD = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY_ALT = 128'hDEADBEEF_00112233_CAFEF00D_55AA55AA;

  localparam logic [0:255][7:0] SB_TBL = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  sm4_key_expand_if kif ();

  sm4_key_expand #(.OUT_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [0:255][7:0] t;
    t = SB_TBL;
    return t[x];
  endfunction

  task automatic gen_model(input logic [127:0] mk);
    logic [31:0] k [4];
    logic [31:0] t, b, r;
    int ck;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      ck = 0;
      for (int j = 0; j < 4; j++) ck = (ck << 8) | (((4*i + j) * 7) & 255);
      t = k[1] ^ k[2] ^ k[3] ^ ck;
      b = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
      r = k[0] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
      exp_rk[i] = r;
      k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = r;
    end
  endtask

  task automatic pulse_start(input logic [127:0] mk);
    kif.key_in    = mk;
    kif.key_start = 1'b1;
    tick();
    kif.key_start = 1'b0;
  endtask

  // counts edges after the start edge until key_ready, bounded
  task automatic wait_ready(output int n);
    n = 0;
    while (!kif.key_ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic read_all(input string tag);
    kif.rk_dec = 1'b0;
    for (int i = 0; i < 32; i++) begin
      kif.rk_idx = 5'(i);
      tick();
      check($sformatf("%s_rk%0d", tag, i), kif.rk_out, exp_rk[i]);
    end
  endtask

  initial begin
    int n;
    kif.key_start = 1'b0;
    kif.key_in    = '0;
    kif.rk_dec    = 1'b0;
    kif.rk_idx    = '0;

    // T1: reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      kif.key_start = 1'($urandom);
      kif.key_in    = {$urandom, $urandom, $urandom, $urandom};
      kif.rk_dec    = 1'($urandom);
      kif.rk_idx    = 5'($urandom);
      tick();
      check("rst_busy",  {31'd0, kif.key_busy},  32'd0);
      check("rst_ready", {31'd0, kif.key_ready}, 32'd0);
      check("rst_rk",    kif.rk_out,             32'd0);
    end
    kif.key_start = 1'b0;
    kif.rk_dec    = 1'b0;
    kif.rk_idx    = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_rk", kif.rk_out, 32'd0);

    // T2: standard vector
    gen_model(KEY_STD);
    pulse_start(KEY_STD);
    check("t2_busy", {31'd0, kif.key_busy}, 32'd1);
    wait_ready(n);
    check("t2_latency", n, 32);
    check("t2_busy_done", {31'd0, kif.key_busy}, 32'd0);
    kif.rk_idx = 5'd0; tick();
    check("t2_rk0_kat", kif.rk_out, 32'hF12186F9);
    kif.rk_idx = 5'd1; tick();
    check("t2_rk1_kat", kif.rk_out, 32'h41662B61);
    kif.rk_idx = 5'd31; tick();
    check("t2_rk31_kat", kif.rk_out, 32'h9124A012);
    read_all("t2");

    // T3: reverse read and 1-cycle read latency
    kif.rk_dec = 1'b1;
    kif.rk_idx = 5'd0;
    tick();
    check("t3_dec0", kif.rk_out, 32'h9124A012);
    kif.rk_idx = 5'd31;
    #1;
    check("t3_latency_hold", kif.rk_out, 32'h9124A012);
    tick();
    check("t3_dec31", kif.rk_out, 32'hF12186F9);
    kif.rk_idx = 5'd5;
    tick();
    check("t3_dec5", kif.rk_out, exp_rk[26]);
    kif.rk_dec = 1'b0;

    // T4: starts during EXPAND are ignored
    pulse_start(KEY_STD);
    check("t4_ready_drop", {31'd0, kif.key_ready}, 32'd0);
    for (int c = 1; c < 5; c++) tick();
    pulse_start(KEY_ALT);
    for (int c = 6; c < 20; c++) tick();
    pulse_start(KEY_ALT);
    n = 20;
    while (!kif.key_ready && n < 100) begin
      tick();
      n++;
    end
    check("t4_latency", n, 32);
    read_all("t4");

    // T5: re-key in DONE with an all-zero key
    gen_model(128'd0);
    pulse_start(128'd0);
    check("t5_ready_drop", {31'd0, kif.key_ready}, 32'd0);
    wait_ready(n);
    check("t5_latency", n, 32);
    read_all("t5");

    // T6: reset mid-EXPAND
    gen_model(KEY_STD);
    pulse_start(KEY_STD);
    for (int c = 1; c < 17; c++) tick();
    check("t6_busy_pre", {31'd0, kif.key_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy_async",  {31'd0, kif.key_busy},  32'd0);
    check("t6_ready_async", {31'd0, kif.key_ready}, 32'd0);
    check("t6_rk_async",    kif.rk_out,             32'd0);
    tick();
    rst_n = 1'b1;
    kif.rk_idx = 5'd0; tick();
    check("t6_tab0_clear", kif.rk_out, 32'd0);
    kif.rk_idx = 5'd15; tick();
    check("t6_tab15_clear", kif.rk_out, 32'd0);
    pulse_start(KEY_STD);
    wait_ready(n);
    check("t6_latency", n, 32);
    read_all("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
